intersection_lamp_ctrl: RTL and testbench



---
 rtl/intersection_lamp_ctrl.sv | 146 ++++++++++++++
 tb/tb_intersection_lamp_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_lamp_ctrl.sv
// Two-road intersection lamp sequencer: NS/EW one-hot lamp groups, timed phases,
// EW-sensor green extension on NS, and a latched pedestrian WALK phase.
module intersection_lamp_ctrl #(
    parameter int unsigned T_GREEN  = 8,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned T_WALK   = 5,
    parameter int unsigned CW       = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ped_req,
    input  logic       ew_car,
    output logic [0:2] ns_light,
    output logic [0:2] ew_light,
    output logic       walk,
    output logic [2:0] phase,
    output logic       ped_pending
);

    typedef enum logic [2:0] {
        S_NS_G  = 3'd0,
        S_NS_Y  = 3'd1,
        S_AR_A  = 3'd2,
        S_EW_G  = 3'd3,
        S_EW_Y  = 3'd4,
        S_AR_B  = 3'd5,
        S_WALK  = 3'd6,
        S_ILL   = 3'd7
    } state_t;

    localparam logic [CW-1:0] LD_GREEN  = CW'(T_GREEN  - 1);
    localparam logic [CW-1:0] LD_YELLOW = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] LD_ALLRED = CW'(T_ALLRED - 1);
    localparam logic [CW-1:0] LD_WALK   = CW'(T_WALK   - 1);

    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;

    // Raw code register so the illegal code 7 stays representable and observable.
    logic [2:0]    state_q;
    state_t        cur;
    state_t        state_d;
    logic [CW-1:0] timer_q;
    logic [CW-1:0] timer_d;
    logic          pend_d;
    logic          expired;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_AR_B;
            timer_q     <= LD_ALLRED;
            ped_pending <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ped_pending <= pend_d;
        end
    end

    always_comb begin
        cur     = state_t'(state_q);
        state_d = cur;
        expired = (timer_q == '0);
        timer_d = expired ? timer_q : timer_q - 1'b1;
        pend_d  = ped_pending | ped_req;

        case (cur)
            S_NS_G: begin
                if (expired) begin
                    if (ew_car || ped_pending) begin
                        state_d = S_NS_Y;
                        timer_d = LD_YELLOW;
                    end else begin
                        timer_d = LD_GREEN;
                    end
                end
            end
            S_NS_Y: begin
                if (expired) begin
                    state_d = S_AR_A;
                    timer_d = LD_ALLRED;
                end
            end
            S_AR_A: begin
                if (expired) begin
                    state_d = S_EW_G;
                    timer_d = LD_GREEN;
                end
            end
            S_EW_G: begin
                if (expired) begin
                    state_d = S_EW_Y;
                    timer_d = LD_YELLOW;
                end
            end
            S_EW_Y: begin
                if (expired) begin
                    state_d = S_AR_B;
                    timer_d = LD_ALLRED;
                end
            end
            S_AR_B: begin
                if (expired) begin
                    if (ped_pending) begin
                        state_d = S_WALK;
                        timer_d = LD_WALK;
                        // A request on this very edge re-arms the latch.
                        pend_d  = ped_req;
                    end else begin
                        state_d = S_NS_G;
                        timer_d = LD_GREEN;
                    end
                end
            end
            S_WALK: begin
                if (expired) begin
                    state_d = S_NS_G;
                    timer_d = LD_GREEN;
                end
            end
            default: begin
                state_d = S_AR_B;
                timer_d = LD_ALLRED;
            end
        endcase
    end

    always_comb begin
        ns_light = RED;
        ew_light = RED;
        walk     = 1'b0;
        case (cur)
            S_NS_G:  ns_light = GREEN;
            S_NS_Y:  ns_light = YELLOW;
            S_EW_G:  ew_light = GREEN;
            S_EW_Y:  ew_light = YELLOW;
            S_WALK:  walk     = 1'b1;
            default: ;
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_intersection_lamp_ctrl.sv
// Scoreboard bench for intersection_lamp_ctrl: a phase/elapsed-cycle reference
// model queues the expected outputs per edge; they are compared on the falling edge.
module tb_intersection_lamp_ctrl;

    localparam int TG  = 8;
    localparam int TY  = 3;
    localparam int TAR = 2;
    localparam int TW  = 5;
    localparam int CW  = 4;
    localparam int TMAX = (TG > TW ? TG : TW) > (TY > TAR ? TY : TAR) ?
                          (TG > TW ? TG : TW) : (TY > TAR ? TY : TAR);

    logic       clock = 1'b0;
    logic       resetn;
    logic       ped_req;
    logic       ew_car;
    logic [0:2] ns_light;
    logic [0:2] ew_light;
    logic       walk;
    logic [2:0] phase;
    logic       ped_pending;

    intersection_lamp_ctrl #(
        .T_GREEN (TG),
        .T_YELLOW(TY),
        .T_ALLRED(TAR),
        .T_WALK  (TW),
        .CW      (CW)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ped_req    (ped_req),
        .ew_car     (ew_car),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .walk       (walk),
        .phase      (phase),
        .ped_pending(ped_pending)
    );

    always #5 clock = ~clock;

    initial assert (TMAX - 1 < (1 << CW))
        else $fatal(1, "FAIL cw_rule: CW=%0d cannot hold %0d", CW, TMAX - 1);

    int vectors     = 0;
    int miscompares = 0;

    typedef logic [10:0] obs_t;   // {ns, ew, walk, phase, pending}
    obs_t exp_q[$];

    int   m_ph;
    int   m_cnt;
    logic m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int dur(input int ph);
        case (ph)
            0, 3:    return TG;
            1, 4:    return TY;
            2, 5:    return TAR;
            6:       return TW;
            default: return 1;
        endcase
    endfunction

    function automatic obs_t model_obs();
        logic [2:0] ns, ew;
        ns = (m_ph == 0) ? 3'b010 : (m_ph == 1) ? 3'b001 : 3'b100;
        ew = (m_ph == 3) ? 3'b010 : (m_ph == 4) ? 3'b001 : 3'b100;
        return {ns, ew, (m_ph == 6), 3'(m_ph), m_pend};
    endfunction

    task automatic model_reset();
        m_ph = 5; m_cnt = 0; m_pend = 1'b0;
    endtask

    task automatic model_step();
        bit ex;
        bit to_walk;
        int nph;
        ex      = (m_cnt == dur(m_ph) - 1);
        to_walk = 0;
        nph     = m_ph;
        if (ex) begin
            case (m_ph)
                0: nph = (ew_car || m_pend) ? 1 : 0;
                1: nph = 2;
                2: nph = 3;
                3: nph = 4;
                4: nph = 5;
                5: begin to_walk = m_pend; nph = m_pend ? 6 : 0; end
                6: nph = 0;
                default: nph = 5;
            endcase
        end
        m_pend = (to_walk ? 1'b0 : m_pend) | ped_req;
        m_cnt  = ex ? 0 : m_cnt + 1;
        m_ph   = nph;
    endtask

    task automatic compare_outputs(input string tag);
        obs_t e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check(tag, {ns_light, ew_light, walk, phase, ped_pending}, e);
        check("lamp_excl", (ns_light != 3'b100) && (ew_light != 3'b100), 0);
    endtask

    task automatic tick();
        @(posedge clock);
        if (!resetn) model_reset();
        else         model_step();
        exp_q.push_back(model_obs());
        @(negedge clock);
        compare_outputs("seq");
    endtask

    initial begin
        int n;
        resetn  = 1'b0;
        ew_car  = 1'b1;
        ped_req = 1'b0;
        model_reset();

        // Reset and two free-running rounds with EW traffic present.
        repeat (3) tick();
        check("rst_lamps", {ns_light, ew_light, walk, phase}, {3'b100, 3'b100, 1'b0, 3'd5});
        resetn = 1'b1;
        repeat (2) tick();
        check("first_ns_g", ns_light, 3'b010);
        repeat (7) tick();
        check("ns_g_len", phase, 0);
        tick();
        check("ns_y_start", phase, 1);
        repeat (18) tick();
        check("period1", phase, 0);
        repeat (26) tick();
        check("period2", phase, 0);

        // No EW traffic: NS green extends; car arrives at cycle 60 of the green.
        ew_car = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("ns_hold", ns_light, 3'b010);
        end
        repeat (19) tick();
        ew_car = 1'b1;
        repeat (4) tick();
        check("ns_g_before_boundary", phase, 0);
        tick();
        check("ns_y_at_boundary", phase, 1);

        // One-cycle pedestrian pulse during EW green.
        repeat (5) tick();
        check("ew_g_reached", phase, 3);
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        check("ped_latched", ped_pending, 1);
        for (int i = 0; i < 40 && !walk; i++) tick();
        check("walk_reached", walk, 1);
        check("walk_clears_pend", ped_pending, 0);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!walk) break;
            n++;
        end
        check("walk_len", n, TW);
        check("post_walk_ns_g", phase, 0);

        // Request held across the AR_B->WALK edge re-arms pending.
        ped_req = 1'b1;
        for (int i = 0; i < 40 && !walk; i++) tick();
        check("walk2_reached", walk, 1);
        check("pend_rearm", ped_pending, 1);
        ped_req = 1'b0;
        for (int i = 0; i < 20 && walk; i++) tick();
        for (int i = 0; i < 40 && !walk; i++) tick();
        check("walk_repeat", walk, 1);
        check("repeat_clears_pend", ped_pending, 0);

        // Asynchronous reset pulse in the middle of EW yellow.
        for (int i = 0; i < 40 && phase != 3'd4; i++) tick();
        check("ew_y_reached", phase, 4);
        tick();
        #2 resetn = 1'b0;
        model_reset();
        exp_q.push_back(model_obs());
        #1 compare_outputs("async_rst");
        check("async_rst_phase", phase, 5);
        tick();
        resetn = 1'b1;
        tick();
        check("rst_ar_b", phase, 5);
        tick();
        check("restart_ns_g", ns_light, 3'b010);

        // Illegal state code 7.
        repeat (3) tick();
        force dut.state_q = 3'd7;
        m_ph  = 7;
        m_cnt = 0;
        exp_q.push_back(model_obs());
        #1 compare_outputs("illegal_out");
        check("illegal_lamps", {ns_light, ew_light, walk}, {3'b100, 3'b100, 1'b0});
        release dut.state_q;
        tick();
        check("illegal_to_ar_b", phase, 5);
        repeat (2) tick();
        check("illegal_recover", phase, 0);
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
